uart_tx: RTL
============

Name: uart_tx

Overview:
UART transmitter, the transmit-side counterpart of the team's uart_rx. It accepts a parallel word over a valid/ready handshake and serialises it LSB-first on tx: start bit (0), DATA_BITS data bits, an optional even-parity bit, and a stop bit (1). It sits between user logic and the board TX pin, and its frame format and BAUD_DIV match uart_rx.

Parameters:
BAUD_DIV, 434, clk cycles per bit (must be >= 2)
DATA_BITS, 8, data bits per frame (5..9)
ENABLE_PARITY, 1, 1 = append even-parity bit after the data bits, 0 = no parity bit

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
valid  input  1  data_in holds a word to send
data_in  input  DATA_BITS  word to transmit
ready  output  1  block can accept a word this cycle
tx  output  1  serial line, idle high
busy  output  1  frame in progress
done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset: when rst is high at a clk edge, the next state is IDLE and all registers clear. Outputs then read tx=1, ready=1, busy=0, done=0. Reset mid-frame aborts the frame and drives tx high on the next cycle. No partial frame resumes.
- Accept: a word is accepted when valid && ready at a clk edge. data_in is latched into a shift register at that edge. Later changes to data_in have no effect. While ready=0, valid is ignored; there is no queueing.
- Registered outputs. For an accept at edge N, from cycle N+1: tx=0 (start bit), ready=0, busy=1.
- State machine (localparam encodings; every state has a distinct value):
  - IDLE -> START on accept.
  - START -> DATA after BAUD_DIV cycles.
  - DATA shifts out bit[0] first and holds each bit for BAUD_DIV cycles. After DATA_BITS bits it goes to PARITY if ENABLE_PARITY, otherwise to STOP.
  - PARITY drives ^data (even parity: total count of 1s, data plus parity bit, is even) for BAUD_DIV cycles, then -> STOP.
  - STOP drives tx=1 for BAUD_DIV cycles, then -> IDLE.
- Baud timing: the baud counter is 16 bits wide. It runs only while not IDLE, restarts at 0 on accept, and wraps at BAUD_DIV-1. A bit advances on the wrap cycle. There is no free-running tick, so there is no phase jitter at the start bit.
- Bit counter width: $clog2(DATA_BITS+1). It clears on entry to DATA.
- Frame length: exactly BAUD_DIV*(2+DATA_BITS+ENABLE_PARITY) cycles of tx activity.
- Completion: on the final STOP cycle, done=1 for exactly one cycle and ready returns to 1 in that same cycle.
  - If valid is high then, the next word is accepted at that edge. Its start bit follows the stop bit with zero idle cycles (back-to-back frames).
- busy is equivalent to state != IDLE. ready equals !busy, or the done cycle.
- tx is driven from a flop, so the output is glitch-free.

Optional Feature:
UART_TX_STOP2_EN.
- Defined: the STOP state lasts 2*BAUD_DIV cycles (two stop bits). Frame length grows by BAUD_DIV. done/ready are asserted on the last cycle of the second stop bit.
- Undefined: exactly one stop bit, as above.

Decomposition:
- Package uart_pkg holds:
  - the shared state encodings (IDLE, START, DATA, PARITY, STOP), so uart_rx and uart_tx agree;
  - the BAUD_DIV default constant;
  - a parity-function helper.
- Sub-module uart_baud_gen: a 16-bit counter with enable and restart inputs and a wrap-pulse output. It is reusable by uart_rx. The remaining FSM and shift register stay in uart_tx.

Test Plan:
All scenarios use BAUD_DIV=4, DATA_BITS=8.
1. ENABLE_PARITY=0, send 8'hA5 -> tx: 4 cycles of 0, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 4 cycles of 1. Frame is 40 cycles; done pulses once at cycle 40.
2. ENABLE_PARITY=1, send 8'h07 -> parity bit 1 (three 1s), frame 44 cycles. Send 8'h03 -> parity bit 0.
3. Hold valid high with 8'h55 then 8'hAA -> second start bit begins the cycle after the first frame's last stop cycle, with no idle gap. ready is high only on the done cycles.
4. Pulse valid with 8'hFF mid-frame while ready=0 -> ignored. The current frame completes unchanged and no second frame is sent.
5. Assert rst at cycle 15 of a frame -> next cycle tx=1, ready=1, busy=0, and done stays 0. A new send of 8'h3C afterwards produces a correct full frame.
6. With UART_TX_STOP2_EN defined, send 8'h00 -> stop high for 8 cycles, frame 44 cycles (parity off).

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Definitions shared by uart_tx and uart_rx. Holds the frame
//               state encodings, the default baud divisor and an even-parity
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default clk cycles per bit (e.g. 50 MHz / 115200 baud).
    localparam int unsigned c_baud_div_default = 434;

    // Frame state encodings. Both directions use these values so a shared
    // debug view reads the same on either side.
    localparam int unsigned c_state_w = 3;
    typedef logic [c_state_w-1:0] uart_state_t;

    localparam uart_state_t c_st_idle   = 3'd0;
    localparam uart_state_t c_st_start  = 3'd1;
    localparam uart_state_t c_st_data   = 3'd2;
    localparam uart_state_t c_st_parity = 3'd3;
    localparam uart_state_t c_st_stop   = 3'd4;

    // Even parity over a word of up to 9 bits. Narrower words are
    // zero-extended by the caller, and zero padding does not change the XOR.
    function automatic logic even_parity(input logic [8:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : 16-bit bit-period counter. It counts while i_en is high,
//               returns to 0 on i_restart and wraps at BAUD_DIV-1. o_wrap
//               marks the last cycle of each bit period.
// Ports       : clk       - system clock
//               rst       - synchronous reset, active-high
//               i_en      - count enable (frame in progress)
//               i_restart - return the count to 0 (takes priority)
//               o_count   - current count within the bit period
//               o_wrap    - high on the last cycle of a bit period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = c_baud_div_default
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_restart,
    output logic [15:0] o_count,
    output logic        o_wrap
);

    localparam logic [15:0] c_last = 16'(BAUD_DIV - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == c_last) ? 16'd0 : r_count + 16'd1;
        end
    end

    assign o_count = r_count;
    assign o_wrap  = i_en && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter. It accepts a word on a valid/ready
//               handshake and sends it LSB-first: a start bit, DATA_BITS
//               data bits, an optional even-parity bit, then the stop bit.
//               A word offered on the done cycle starts straight after the
//               stop bit, with no idle gap.
// Ports       : clk     - system clock
//               rst     - synchronous reset, active-high
//               valid   - data_in holds a word to send
//               data_in - word to transmit
//               ready   - a word can be accepted this cycle
//               tx      - serial line, idle high, driven from a flop
//               busy    - frame in progress
//               done    - one-cycle pulse on the last stop-bit cycle
// Options     : UART_TX_STOP2_EN - when defined, two stop bits are sent
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV      = c_baud_div_default,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned ENABLE_PARITY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned c_bit_cnt_w = $clog2(DATA_BITS + 1);
    localparam logic [c_bit_cnt_w-1:0] c_last_bit  = c_bit_cnt_w'(DATA_BITS - 1);
    localparam logic [c_bit_cnt_w-1:0] c_bit_one   = c_bit_cnt_w'(1);
    localparam logic [15:0]            c_cnt_prelast = 16'(BAUD_DIV - 2);

    uart_state_t            r_state;
    logic [DATA_BITS-1:0]   r_shreg;
    logic [c_bit_cnt_w-1:0] r_bit_cnt;
    logic                   r_parity;
    logic                   r_tx;
    logic                   r_done;

    logic        w_busy;
    logic        w_accept;
    logic        w_wrap;
    logic        w_stop_last;
    logic [15:0] w_baud_count;

    assign w_busy   = (r_state != c_st_idle);
    // The done cycle reopens the handshake so frames can run back-to-back.
    assign w_accept = valid && ready;

    assign ready = !w_busy || r_done;
    assign busy  = w_busy;
    assign tx    = r_tx;
    assign done  = r_done;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_busy),
        .i_restart (w_accept),
        .o_count   (w_baud_count),
        .o_wrap    (w_wrap)
    );

`ifdef UART_TX_STOP2_EN
    // Marks that the first of the two stop-bit periods has elapsed.
    logic r_stop_second;

    always_ff @(posedge clk) begin
        if (rst || (r_state != c_st_stop)) begin
            r_stop_second <= 1'b0;
        end else if (w_wrap) begin
            r_stop_second <= !r_stop_second;
        end
    end

    assign w_stop_last = r_stop_second;
`else
    assign w_stop_last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            // done is computed one cycle early so that it comes straight
            // from a flop and lines up with the final stop cycle.
            r_done <= (r_state == c_st_stop) && w_stop_last &&
                      (w_baud_count == c_cnt_prelast);

            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_state  <= c_st_start;
                        r_tx     <= 1'b0;
                        r_shreg  <= data_in;
                        r_parity <= even_parity(9'(data_in));
                    end
                end

                c_st_start: begin
                    if (w_wrap) begin
                        r_state   <= c_st_data;
                        r_tx      <= r_shreg[0];
                        r_shreg   <= r_shreg >> 1;
                        r_bit_cnt <= '0;
                    end
                end

                c_st_data: begin
                    if (w_wrap) begin
                        if (r_bit_cnt == c_last_bit) begin
                            if (ENABLE_PARITY != 0) begin
                                r_state <= c_st_parity;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= c_st_stop;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_tx      <= r_shreg[0];
                            r_shreg   <= r_shreg >> 1;
                            r_bit_cnt <= r_bit_cnt + c_bit_one;
                        end
                    end
                end

                c_st_parity: begin
                    if (w_wrap) begin
                        r_state <= c_st_stop;
                        r_tx    <= 1'b1;
                    end
                end

                c_st_stop: begin
                    if (w_wrap && w_stop_last) begin
                        if (w_accept) begin
                            r_state  <= c_st_start;
                            r_tx     <= 1'b0;
                            r_shreg  <= data_in;
                            r_parity <= even_parity(9'(data_in));
                        end else begin
                            r_state <= c_st_idle;
                            r_tx    <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
